// File: rtl/div_seq_ctrl.sv
// -----------------------------------------------------------------------------
// div_seq_ctrl
//
// Sequencing front end for an iterative integer divider. The block accepts
// one DIV/DIVU/REM/REMU operation at a time from the issue stage and holds
// its operands and tag in registers. It fires a single-cycle request at the
// divider and waits for the divider's done cycle. It then captures the
// quotient or the remainder and presents it on a valid/ready writeback port
// until that port consumes it.
//
// The divider owns all arithmetic corner cases: divide-by-zero, signed
// overflow and sign extension of 32-bit results. This block forwards the
// captured value unchanged.
//
// Ports
//   clk_i, rstn_i        clock; asynchronous active-low reset
//   flush_i              pipeline kill: drops any held or in-flight operation
//   req_valid_i/ready_o  issue handshake
//   req_op_i             00=DIV 01=DIVU 10=REM 11=REMU
//   req_int32_i          32-bit (W) variant
//   req_rs1_i/rs2_i      dividend / divisor
//   req_tag_i            tag returned with the result
//   div_request_o        one-cycle start pulse to the divider
//   div_kill_o           abort to the divider (mirrors flush_i)
//   div_int_32_o         W-variant select to the divider
//   div_signed_o         signed operation select to the divider
//   div_dvnd_o/dvsr_o    operands to the divider, stable while in flight
//   div_quo_i/rmd_i      divider results, valid in the done cycle only
//   div_stall_i          divider busy; low while in BUSY marks the done cycle
//   wb_valid_o/ready_i   writeback handshake
//   wb_data_o, wb_tag_o  writeback payload
// -----------------------------------------------------------------------------
module div_seq_ctrl #(
  parameter int TAG_W = 7
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             flush_i,

  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic             req_int32_i,
  input  logic [63:0]      req_rs1_i,
  input  logic [63:0]      req_rs2_i,
  input  logic [TAG_W-1:0] req_tag_i,

  output logic             div_request_o,
  output logic             div_kill_o,
  output logic             div_int_32_o,
  output logic             div_signed_o,
  output logic [63:0]      div_dvnd_o,
  output logic [63:0]      div_dvsr_o,
  input  logic [63:0]      div_quo_i,
  input  logic [63:0]      div_rmd_i,
  input  logic             div_stall_i,

  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [63:0]      wb_data_o,
  output logic [TAG_W-1:0] wb_tag_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state_reg;
  logic [1:0]         op_reg;
  logic               int32_reg;
  logic [63:0]        rs1_reg;
  logic [63:0]        rs2_reg;
  logic [TAG_W-1:0]   tag_reg;
  logic [63:0]        wb_data_reg;
  logic               wb_valid_reg;

  // A flush blocks acceptance in the same cycle. Otherwise an operation
  // would be taken into a machine that is being cleared.
  assign req_ready_o   = (state_reg == IDLE) && !flush_i;

  // The request pulse is qualified by flush. This keeps a killed operation
  // from ever starting in the divider.
  assign div_request_o = (state_reg == ISSUE) && !flush_i;
  assign div_kill_o    = flush_i;

  // The divider sees the registered operation for as long as it stays
  // registered. The operation register is only reloaded in IDLE, so these
  // outputs remain stable from ISSUE through the capture cycle.
  assign div_dvnd_o    = rs1_reg;
  assign div_dvsr_o    = rs2_reg;
  assign div_int_32_o  = int32_reg;
  assign div_signed_o  = ~op_reg[0];

  assign wb_valid_o    = wb_valid_reg;
  assign wb_data_o     = wb_data_reg;
  assign wb_tag_o      = tag_reg;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg    <= IDLE;
      op_reg       <= 2'b00;
      int32_reg    <= 1'b0;
      rs1_reg      <= 64'd0;
      rs2_reg      <= 64'd0;
      tag_reg      <= '0;
      wb_data_reg  <= 64'd0;
      wb_valid_reg <= 1'b0;
    end else if (flush_i) begin
      // A kill wins over every transition, including a writeback handshake
      // in HOLD. The result is dropped and never handed over.
      state_reg    <= IDLE;
      wb_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid_i) begin
            op_reg    <= req_op_i;
            int32_reg <= req_int32_i;
            rs1_reg   <= req_rs1_i;
            rs2_reg   <= req_rs2_i;
            tag_reg   <= req_tag_i;
            state_reg <= ISSUE;
          end
        end

        ISSUE: begin
          state_reg <= BUSY;
        end

        BUSY: begin
          // The first cycle in BUSY with stall low is the divider's done
          // cycle. Its results are only valid in that cycle.
          if (!div_stall_i) begin
            wb_data_reg  <= op_reg[1] ? div_rmd_i : div_quo_i;
            wb_valid_reg <= 1'b1;
            state_reg    <= HOLD;
          end
        end

        HOLD: begin
          // On a handshake the block returns to IDLE. A new request can
          // therefore be accepted in the next cycle at the earliest.
          if (wb_ready_i) begin
            wb_valid_reg <= 1'b0;
            state_reg    <= IDLE;
          end
        end

        default: begin
          state_reg    <= IDLE;
          wb_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
module tb_div_seq_ctrl;

  localparam int TAG_W = 7;

  logic             clk = 1'b0;
  logic             rstn_i = 1'b0;
  logic             flush_i = 1'b0;
  logic             req_valid_i = 1'b0;
  logic             req_ready_o;
  logic [1:0]       req_op_i = 2'b00;
  logic             req_int32_i = 1'b0;
  logic [63:0]      req_rs1_i = 64'd0;
  logic [63:0]      req_rs2_i = 64'd0;
  logic [TAG_W-1:0] req_tag_i = '0;
  logic             div_request_o;
  logic             div_kill_o;
  logic             div_int_32_o;
  logic             div_signed_o;
  logic [63:0]      div_dvnd_o;
  logic [63:0]      div_dvsr_o;
  logic [63:0]      div_quo_i;
  logic [63:0]      div_rmd_i;
  logic             div_stall_i;
  logic             wb_valid_o;
  logic             wb_ready_i = 1'b1;
  logic [63:0]      wb_data_o;
  logic [TAG_W-1:0] wb_tag_o;

  always #5 clk = ~clk;

  div_seq_ctrl #(.TAG_W(TAG_W)) dut (
    .clk_i         (clk),
    .rstn_i        (rstn_i),
    .flush_i       (flush_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_op_i      (req_op_i),
    .req_int32_i   (req_int32_i),
    .req_rs1_i     (req_rs1_i),
    .req_rs2_i     (req_rs2_i),
    .req_tag_i     (req_tag_i),
    .div_request_o (div_request_o),
    .div_kill_o    (div_kill_o),
    .div_int_32_o  (div_int_32_o),
    .div_signed_o  (div_signed_o),
    .div_dvnd_o    (div_dvnd_o),
    .div_dvsr_o    (div_dvsr_o),
    .div_quo_i     (div_quo_i),
    .div_rmd_i     (div_rmd_i),
    .div_stall_i   (div_stall_i),
    .wb_valid_o    (wb_valid_o),
    .wb_ready_i    (wb_ready_i),
    .wb_data_o     (wb_data_o),
    .wb_tag_o      (wb_tag_o)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference semantics of RISC-V M-extension divide/remainder.
  function automatic logic [63:0] ref_div(input logic [1:0] op, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
    logic        is_signed;
    logic        is_rem;
    logic [31:0] r32;
    logic [63:0] r64;
    int          sa32, sb32;
    longint      sa64, sb64;
    is_signed = ~op[0];
    is_rem    = op[1];
    if (w) begin
      sa32 = $signed(a[31:0]);
      sb32 = $signed(b[31:0]);
      if (b[31:0] == 32'd0)
        r32 = is_rem ? a[31:0] : 32'hFFFF_FFFF;
      else if (is_signed) begin
        if (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
          r32 = is_rem ? 32'd0 : a[31:0];
        else
          r32 = is_rem ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
      end else
        r32 = is_rem ? (a[31:0] % b[31:0]) : (a[31:0] / b[31:0]);
      return {{32{r32[31]}}, r32};
    end
    sa64 = $signed(a);
    sb64 = $signed(b);
    if (b == 64'd0)
      r64 = is_rem ? a : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (is_signed) begin
      if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF)
        r64 = is_rem ? 64'd0 : a;
      else
        r64 = is_rem ? 64'(sa64 % sb64) : 64'(sa64 / sb64);
    end else
      r64 = is_rem ? (a % b) : (a / b);
    return r64;
  endfunction

  // Divider model: fixed latency, 32 stall cycles for 64-bit ops and 16 for
  // W ops. The results are computed from whatever the DUT drives in the done
  // cycle.
  int dv_cnt = 0;
  always @(posedge clk) begin
    if (!rstn_i || div_kill_o) dv_cnt <= 0;
    else if (div_request_o)    dv_cnt <= div_int_32_o ? 16 : 32;
    else if (dv_cnt != 0)      dv_cnt <= dv_cnt - 1;
  end
  assign div_stall_i = (dv_cnt != 0);
  always_comb begin
    div_quo_i = ref_div({1'b0, ~div_signed_o}, div_int_32_o, div_dvnd_o, div_dvsr_o);
    div_rmd_i = ref_div({1'b1, ~div_signed_o}, div_int_32_o, div_dvnd_o, div_dvsr_o);
  end

  // Writeback-ready driver: 0 = always ready, 1 = random, 2 = manual.
  int   rdy_mode = 0;
  logic rdy_manual = 1'b1;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       wb_ready_i = 1'b1;
      1:       wb_ready_i = 1'($urandom_range(0, 1));
      default: wb_ready_i = rdy_manual;
    endcase
  end

  typedef struct {
    logic [63:0]      data;
    logic [TAG_W-1:0] tag;
    int               due;
  } exp_t;
  exp_t sb_q[$];

  // Monitor and scoreboard.
  logic             prev_v = 1'b0;
  logic [63:0]      held_d;
  logic [TAG_W-1:0] held_t;
  int               vcyc = 0;
  int               hs = 0;
  int               rq = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rstn_i) begin
      prev_v = 1'b0;
    end else begin
      if (wb_valid_o && !prev_v) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wb_valid: got data %h tag %0d expected no result (cycle %0d)",
                   wb_data_o, wb_tag_o, cyc);
        end else begin
          e = sb_q.pop_front();
          $display("wb tag=%0d data=%h cycle=%0d", wb_tag_o, wb_data_o, cyc);
          chk("wb_data", wb_data_o, e.data);
          chk("wb_tag", 64'(wb_tag_o), 64'(e.tag));
          chk("wb_latency_cycle", 64'(cyc), 64'(e.due));
        end
        held_d = wb_data_o;
        held_t = wb_tag_o;
      end else if (wb_valid_o) begin
        chk("hold_data_stable", wb_data_o, held_d);
        chk("hold_tag_stable", 64'(wb_tag_o), 64'(held_t));
        chk("hold_ready_low", 64'(req_ready_o), 64'd0);
      end
      if (wb_valid_o) vcyc++;
      if (wb_valid_o && wb_ready_i && !flush_i) hs++;
      if (div_request_o) rq++;
      prev_v = wb_valid_o;
    end
  end

  task automatic issue(input logic [1:0] op, input logic w, input logic [63:0] a,
                       input logic [63:0] b, input logic [TAG_W-1:0] tag);
    exp_t e;
    int   n;
    bit   done;
    n    = 0;
    done = 0;
    @(posedge clk); #1;
    req_op_i    = op;
    req_int32_i = w;
    req_rs1_i   = a;
    req_rs2_i   = b;
    req_tag_i   = tag;
    req_valid_i = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (req_ready_o) begin
        e.data = ref_div(op, w, a, b);
        e.tag  = tag;
        e.due  = cyc + (w ? 19 : 35);
        sb_q.push_back(e);
        done = 1;
      end
      @(posedge clk); #1;
      if (!done) begin
        n++;
        if (n > 300) begin
          checks++;
          errors++;
          $display("FAIL issue_timeout: got req_ready_o low for %0d cycles expected acceptance", n);
          done = 1;
        end
      end
    end
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !wb_valid_o && req_ready_o) return;
    end
    checks++;
    errors++;
    $display("FAIL idle_timeout: got %0d pending results expected 0", sb_q.size());
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (wb_valid_o) return;
    end
    checks++;
    errors++;
    $display("FAIL valid_timeout: got wb_valid_o 0 expected 1");
  endtask

  task automatic check_reset_outputs(input string tagname);
    chk({tagname, "_req_ready"},   64'(req_ready_o),   64'd1);
    chk({tagname, "_div_request"}, 64'(div_request_o), 64'd0);
    chk({tagname, "_div_kill"},    64'(div_kill_o),    64'd0);
    chk({tagname, "_wb_valid"},    64'(wb_valid_o),    64'd0);
    chk({tagname, "_wb_data"},     wb_data_o,          64'd0);
    chk({tagname, "_wb_tag"},      64'(wb_tag_o),      64'd0);
    chk({tagname, "_dvnd"},        div_dvnd_o,         64'd0);
    chk({tagname, "_dvsr"},        div_dvsr_o,         64'd0);
    chk({tagname, "_int32"},       64'(div_int_32_o),  64'd0);
    chk({tagname, "_signed"},      64'(div_signed_o),  64'd1);
  endtask

  function automatic logic [63:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0000_0000_8000_0000;
      4: return 64'($urandom_range(0, 20));
      default: return {32'($urandom), 32'($urandom)};
    endcase
  endfunction

  initial begin
    int v0, r0, h0;
    #12;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rstn_i = 1'b1;

    // 64-bit DIV 100/7: one request, one-cycle result pulse.
    v0 = vcyc; r0 = rq;
    issue(2'b00, 1'b0, 64'd100, 64'd7, 7'd5);
    wait_idle();
    chk("div100_7_pulse_len", 64'(vcyc - v0), 64'd1);
    chk("div100_7_requests", 64'(rq - r0), 64'd1);

    // REMW with a negative dividend.
    issue(2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 7'd11);
    wait_idle();

    // DIVU and REMU by zero.
    issue(2'b01, 1'b0, 64'd9, 64'd0, 7'd12);
    issue(2'b11, 1'b0, 64'd9, 64'd0, 7'd13);
    wait_idle();

    // Flush in the middle of a 64-bit op.
    issue(2'b00, 1'b0, 64'd123456, 64'd789, 7'd20);
    repeat (9) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk("flush_kill", 64'(div_kill_o), 64'd1);
    chk("flush_ready_blocked", 64'(req_ready_o), 64'd0);
    @(posedge clk); #1 flush_i = 1'b0;
    @(negedge clk);
    chk("post_flush_ready", 64'(req_ready_o), 64'd1);
    chk("post_flush_valid", 64'(wb_valid_o), 64'd0);
    issue(2'b00, 1'b0, 64'd20, 64'd4, 7'd21);
    wait_idle();

    // Flush during ISSUE suppresses the request pulse.
    r0 = rq;
    issue(2'b01, 1'b0, 64'd50, 64'd5, 7'd22);
    flush_i = 1'b1;
    sb_q.delete();
    @(negedge clk);
    chk("issue_flush_no_request", 64'(div_request_o), 64'd0);
    @(posedge clk); #1 flush_i = 1'b0;
    @(negedge clk);
    chk("issue_flush_request_count", 64'(rq - r0), 64'd0);

    // Writeback back-pressure for six cycles.
    rdy_mode = 2; rdy_manual = 1'b0;
    issue(2'b00, 1'b0, 64'd1000, 64'd3, 7'd30);
    wait_valid();
    repeat (5) @(negedge clk);
    chk("stall_valid_held", 64'(wb_valid_o), 64'd1);
    chk("stall_ready_low", 64'(req_ready_o), 64'd0);
    rdy_manual = 1'b1;
    @(negedge clk);
    chk("release_valid", 64'(wb_valid_o), 64'd1);
    @(negedge clk);
    chk("release_idle_valid", 64'(wb_valid_o), 64'd0);
    chk("release_idle_ready", 64'(req_ready_o), 64'd1);

    // A flush coincident with wb_ready in HOLD discards the result.
    rdy_manual = 1'b0;
    issue(2'b10, 1'b1, 64'd77, 64'd10, 7'd31);
    wait_valid();
    h0 = hs;
    rdy_manual = 1'b1;
    @(posedge clk); #1 flush_i = 1'b1;
    @(negedge clk);
    chk("hold_flush_kill", 64'(div_kill_o), 64'd1);
    @(posedge clk); #1 flush_i = 1'b0;
    @(negedge clk);
    chk("hold_flush_valid_drop", 64'(wb_valid_o), 64'd0);
    chk("hold_flush_no_handshake", 64'(hs - h0), 64'd0);
    rdy_mode = 0;

    // Reset in the middle of an operation.
    v0 = vcyc;
    issue(2'b00, 1'b0, 64'd999, 64'd9, 7'd40);
    repeat (19) begin @(posedge clk); #1; end
    rstn_i = 1'b0;
    sb_q.delete();
    #1;
    check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #1 rstn_i = 1'b1;
    chk("midreset_no_valid", 64'(vcyc - v0), 64'd0);
    issue(2'b00, 1'b0, 64'd100, 64'd7, 7'd41);
    wait_idle();

    // Randomized traffic with random writeback back-pressure.
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      repeat (gap) @(posedge clk);
      issue(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            rand_operand(), rand_operand(), 7'($urandom_range(0, 127)));
    end
    rdy_mode = 0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: got no completion expected finish before %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

endmodule
